sync_1101_tx: RTL and testbench

SYNC_1101_TX -- requirements
Module: sync_1101_tx

---
 rtl/sync_1101_tx.sv | 128 ++++++++++++
 tb/tb_sync_1101_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sync_1101_tx.sv
// Serial frame transmitter: 1101 preamble, MSB-first payload, optional even parity (PARITY_EN), one gap bit.
// All outputs are registered and decoded from the next state so each bit appears the cycle after its edge.
module sync_1101_tx #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 x_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(PAYLOAD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);
  localparam logic [3:0] PREAMBLE = 4'b1101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
`ifdef PARITY_EN
    PAR  = 3'd3,
`endif
    GAP  = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [1:0]           sync_cnt, sync_cnt_next;
  logic [PAYLOAD_W-1:0] shift_reg, shift_next;
  logic                 x_next, busy_next, done_next;
`ifdef PARITY_EN
  logic                 parity_bit, parity_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sync_cnt  <= '0;
      shift_reg <= '0;
      x_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      sync_cnt  <= sync_cnt_next;
      shift_reg <= shift_next;
      x_out     <= x_next;
      busy      <= busy_next;
      done      <= done_next;
`ifdef PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    sync_cnt_next = sync_cnt;
    shift_next    = shift_reg;
`ifdef PARITY_EN
    parity_next   = parity_bit;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = SYNC;
          shift_next    = data_in;
          bit_cnt_next  = '0;
          sync_cnt_next = '0;
`ifdef PARITY_EN
          parity_next   = ^data_in;
`endif
        end
      end
      SYNC: begin
        if (sync_cnt == 2'd3) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end else begin
          sync_cnt_next = sync_cnt + 2'd1;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
          state_next = PAR;
`else
          state_next = GAP;
`endif
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
          shift_next   = shift_reg << 1;
        end
      end
`ifdef PARITY_EN
      PAR:     state_next = GAP;
`endif
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values belong to the state being entered, so they line up with it once registered.
  always_comb begin
    x_next    = 1'b0;
    busy_next = (state_next != IDLE);
    done_next = 1'b0;
    case (state_next)
      SYNC: x_next = PREAMBLE[~sync_cnt_next];
      DATA: x_next = shift_next[PAYLOAD_W-1];
`ifdef PARITY_EN
      PAR:  x_next = parity_next;
`endif
      GAP:  done_next = 1'b1;
      default: x_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sync_1101_tx.sv
// Directed bench for sync_1101_tx (PAYLOAD_W=8); parity expectations follow PARITY_EN.
module tb_sync_1101_tx;

`ifdef PARITY_EN
  localparam int  FRAME_LEN = 14;
  localparam bit  PAR_ON    = 1'b1;
`else
  localparam int  FRAME_LEN = 13;
  localparam bit  PAR_ON    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       x_out, busy, done;

  int checks = 0;
  int failures = 0;

  sync_1101_tx #(.PAYLOAD_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data_in(data_in),
    .x_out(x_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    start   = s;
    data_in = d;
  endtask

  function automatic logic expBit(input logic [7:0] payload, input int i);
    logic [3:0] pre;
    pre = 4'b1101;
    if (i < 4)                  return pre[3-i];
    else if (i < 12)            return payload[11-i];
    else if (i == 12 && PAR_ON) return ^payload;
    else                        return 1'b0;
  endfunction

  // Called right after the accepting edge; checks every frame cycle and ends in the cycle after GAP.
  task automatic checkFrame(input string tag, input logic [7:0] payload, input bit disturb);
    for (int i = 0; i < FRAME_LEN; i++) begin
      checkOutput($sformatf("%s.x%0d", tag, i), {31'b0, x_out}, {31'b0, expBit(payload, i)});
      checkOutput($sformatf("%s.busy%0d", tag, i), {31'b0, busy}, 32'd1);
      checkOutput($sformatf("%s.done%0d", tag, i), {31'b0, done}, {31'b0, (i == FRAME_LEN - 1)});
      if (disturb && i == 6) applyStimulus(1'b1, 8'h3C);
      if (disturb && i == 7) applyStimulus(1'b0, 8'h3C);
      tick();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".x"}, {31'b0, x_out}, 32'd0);
    checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [3:0] hist;
    int det;

    // Reset state, with start asserted to show reset wins.
    applyStimulus(1'b1, 8'hA5);
    tick();
    tick();
    checkIdle("reset");
    applyStimulus(1'b0, 8'h00);
    reset = 1'b0;
    tick();
    checkIdle("idle_no_start");

    // Single 0xA5 frame.
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("a5", 8'hA5, 1'b0);
    checkIdle("a5_after");

    // start held high: back-to-back frames, data change after capture ignored.
    applyStimulus(1'b1, 8'hFF);
    tick();
    applyStimulus(1'b1, 8'h00);
    checkFrame("ff", 8'hFF, 1'b0);
    checkIdle("gap_idle");
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("00", 8'h00, 1'b0);
    checkIdle("00_after");

    // Re-pulse start and change data_in mid-frame.
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'hA5);
    checkFrame("a5_dist", 8'hA5, 1'b1);
    checkIdle("dist_after0");
    tick();
    checkIdle("dist_after1");
    tick();
    checkIdle("dist_after2");

    // Reset during the 3rd payload bit.
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'hA5);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("mid.x_before", {31'b0, x_out}, {31'b0, expBit(8'hA5, 6)});
    reset = 1'b1;
    tick();
    checkIdle("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkIdle($sformatf("post_reset%0d", i));
    end
    applyStimulus(1'b1, 8'h81);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("81", 8'h81, 1'b0);

    // Parity-sensitive payload.
    applyStimulus(1'b1, 8'h01);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame("01", 8'h01, 1'b0);

    // Loopback into a 1101 detector with an all-zero payload.
    tick();
    applyStimulus(1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00);
    hist = 4'b0000;
    det = 0;
    for (int i = 0; i < FRAME_LEN + 3; i++) begin
      hist = {hist[2:0], x_out};
      if (hist == 4'b1101) det++;
      tick();
    end
    checkOutput("loopback_det", det, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
